// File: rtl/up16_io_pkg.sv
// Shared types and frame constants for the up16 serial I/O peripheral.
package up16_io_pkg;
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_t;

  localparam int DATA_BITS  = 8;
  localparam int FRAME_BITS = 10;
endpackage

// File: rtl/io_uart_if.sv
// CPU-side register/flag bundle between the up16 core and io_uart.
interface io_uart_if;
  logic [7:0] outr;
  logic       out_load;
  logic       inp_ack;
  logic       err_clr;
  logic [7:0] inpr;
  logic       fgi;
  logic       fgo;
  logic       rx_ovr;
  logic       frame_err;

  modport master (
    output outr, out_load, inp_ack, err_clr,
    input  inpr, fgi, fgo, rx_ovr, frame_err
  );

  modport slave (
    input  outr, out_load, inp_ack, err_clr,
    output inpr, fgi, fgo, rx_ovr, frame_err
  );
endinterface

// File: rtl/io_uart_rx.sv
// 8N1 receiver: input synchronizer, mid-bit sampling FSM and the INPR/FGI/error flags.
module io_uart_rx
  import up16_io_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  input  logic       inp_ack,
  input  logic       err_clr,
  output logic [7:0] inpr,
  output logic       fgi,
  output logic       rx_ovr,
  output logic       frame_err
);
  localparam int             CW        = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0]  CNT_ZERO  = {CW{1'b0}};
  localparam logic [CW-1:0]  CNT_ONE   = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0]  CNT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0]  CNT_HALF  = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [2:0]     LAST_BIT  = 3'(DATA_BITS - 1);

  logic          rx_meta_r, rx_sync_r, rx_prev_r;
  uart_state_t   state_r, state_s;
  logic [CW-1:0] cnt_r, cnt_s;
  logic [2:0]    bit_r, bit_s;
  logic [7:0]    shift_r, shift_s;
  logic [7:0]    inpr_r, inpr_s;
  logic          fgi_r, fgi_s;
  logic          ovr_r, ovr_s;
  logic          ferr_r, ferr_s;
  logic          done_s, bad_s;

  // Next-state, sampling and flag logic.
  always_comb begin
    state_s = state_r;
    cnt_s   = (cnt_r == CNT_LAST) ? CNT_ZERO : cnt_r + CNT_ONE;
    bit_s   = bit_r;
    shift_s = shift_r;
    inpr_s  = inpr_r;
    done_s  = 1'b0;
    bad_s   = 1'b0;

    case (state_r)
      IDLE: begin
        cnt_s = CNT_ZERO;
        if (rx_prev_r && !rx_sync_r) begin
          state_s = START;
        end else begin
          state_s = IDLE;
        end
      end
      START: begin
        if (cnt_r == CNT_HALF) begin
          cnt_s   = CNT_ZERO;
          bit_s   = 3'd0;
          state_s = rx_sync_r ? IDLE : DATA;
        end else begin
          state_s = START;
        end
      end
      DATA: begin
        if (cnt_r == CNT_LAST) begin
          shift_s = {rx_sync_r, shift_r[7:1]};
          if (bit_r == LAST_BIT) begin
            state_s = STOP;
          end else begin
            bit_s = bit_r + 3'd1;
          end
        end else begin
          state_s = DATA;
        end
      end
      STOP: begin
        if (cnt_r == CNT_LAST) begin
          state_s = IDLE;
          done_s  = rx_sync_r;
          bad_s   = !rx_sync_r;
        end else begin
          state_s = STOP;
        end
      end
      default: begin
        state_s = IDLE;
        cnt_s   = CNT_ZERO;
      end
    endcase

    fgi_s  = inp_ack ? 1'b0 : fgi_r;
    ovr_s  = err_clr ? 1'b0 : ovr_r;
    ferr_s = err_clr ? 1'b0 : ferr_r;

    // A completed byte always lands; overrun only if the previous one is still unread.
    if (done_s) begin
      inpr_s = shift_r;
      fgi_s  = 1'b1;
      if (fgi_r && !inp_ack) begin
        ovr_s = 1'b1;
      end else begin
        ovr_s = ovr_s;
      end
    end else begin
      inpr_s = inpr_s;
    end

    if (bad_s) begin
      ferr_s = 1'b1;
    end else begin
      ferr_s = ferr_s;
    end
  end

  // Synchronizer, FSM and flag registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta_r <= 1'b1;
      rx_sync_r <= 1'b1;
      rx_prev_r <= 1'b1;
      state_r   <= IDLE;
      cnt_r     <= CNT_ZERO;
      bit_r     <= 3'd0;
      shift_r   <= 8'h00;
      inpr_r    <= 8'h00;
      fgi_r     <= 1'b0;
      ovr_r     <= 1'b0;
      ferr_r    <= 1'b0;
    end else begin
      rx_meta_r <= rx;
      rx_sync_r <= rx_meta_r;
      rx_prev_r <= rx_sync_r;
      state_r   <= state_s;
      cnt_r     <= cnt_s;
      bit_r     <= bit_s;
      shift_r   <= shift_s;
      inpr_r    <= inpr_s;
      fgi_r     <= fgi_s;
      ovr_r     <= ovr_s;
      ferr_r    <= ferr_s;
    end
  end

  assign inpr      = inpr_r;
  assign fgi       = fgi_r;
  assign rx_ovr    = ovr_r;
  assign frame_err = ferr_r;
endmodule

// File: rtl/io_uart.sv
// up16 serial I/O peripheral: 8N1 transmitter for OUTR/FGO plus the io_uart_rx receiver for INPR/FGI.
module io_uart
  import up16_io_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic       tx,
  io_uart_if.slave   bus
);
  localparam int             CW       = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0]  CNT_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0]  CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0]  CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [2:0]     LAST_BIT = 3'(DATA_BITS - 1);

  uart_state_t   state_r, state_s;
  logic [CW-1:0] cnt_r, cnt_s;
  logic [2:0]    bit_r, bit_s;
  logic [7:0]    shift_r, shift_s;
  logic          tx_r, tx_s;
  logic          fgo_r, fgo_s;
  logic          bit_end_s;

  assign bit_end_s = (cnt_r == CNT_LAST);

  // TX next-state and line/flag logic; tx and fgo are computed here and registered below.
  always_comb begin
    state_s = state_r;
    cnt_s   = bit_end_s ? CNT_ZERO : cnt_r + CNT_ONE;
    bit_s   = bit_r;
    shift_s = shift_r;
    tx_s    = tx_r;
    fgo_s   = fgo_r;

    case (state_r)
      IDLE: begin
        cnt_s = CNT_ZERO;
        if (bus.out_load && fgo_r) begin
          state_s = START;
          shift_s = bus.outr;
          tx_s    = 1'b0;
          fgo_s   = 1'b0;
        end else begin
          state_s = IDLE;
          tx_s    = 1'b1;
        end
      end
      START: begin
        if (bit_end_s) begin
          state_s = DATA;
          bit_s   = 3'd0;
          tx_s    = shift_r[0];
          shift_s = {1'b0, shift_r[7:1]};
        end else begin
          state_s = START;
        end
      end
      DATA: begin
        if (bit_end_s) begin
          if (bit_r == LAST_BIT) begin
            state_s = STOP;
            tx_s    = 1'b1;
          end else begin
            bit_s   = bit_r + 3'd1;
            tx_s    = shift_r[0];
            shift_s = {1'b0, shift_r[7:1]};
          end
        end else begin
          state_s = DATA;
        end
      end
      STOP: begin
        if (bit_end_s) begin
          state_s = IDLE;
          fgo_s   = 1'b1;
        end else begin
          state_s = STOP;
        end
      end
      default: begin
        state_s = IDLE;
        cnt_s   = CNT_ZERO;
        tx_s    = 1'b1;
        fgo_s   = 1'b1;
      end
    endcase
  end

  // TX state and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      cnt_r   <= CNT_ZERO;
      bit_r   <= 3'd0;
      shift_r <= 8'h00;
      tx_r    <= 1'b1;
      fgo_r   <= 1'b1;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      bit_r   <= bit_s;
      shift_r <= shift_s;
      tx_r    <= tx_s;
      fgo_r   <= fgo_s;
    end
  end

  assign tx      = tx_r;
  assign bus.fgo = fgo_r;

  io_uart_rx #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_rx (
    .clk       (clk),
    .rst       (rst),
    .rx        (rx),
    .inp_ack   (bus.inp_ack),
    .err_clr   (bus.err_clr),
    .inpr      (bus.inpr),
    .fgi       (bus.fgi),
    .rx_ovr    (bus.rx_ovr),
    .frame_err (bus.frame_err)
  );
endmodule

// File: doc/io_uart.md
Name: io_uart

Overview:
Serial I/O peripheral that sits directly downstream of the cpu's display port and upstream of its keyboard port. It replaces the bench-driven keyboard byte and I/O flags with a real 8N1 UART link.
- Transmit: serializes the byte the cpu writes to OUTR and drives the output flag (FGO).
- Receive: deserializes incoming bytes into INPR and drives the input flag (FGI).
- fgi/fgo feed the cpu's en_inp/en_out directly.

Parameters:
CLKS_PER_BIT, 16, clk cycles per UART bit (minimum 4; 16 used in simulation).

Ports:
clk  input  1  system clock; all state changes on rising edge.
rst  input  1  synchronous, active-high reset.
outr  input  8  cpu OUTR (display) byte.
out_load  input  1  one-cycle pulse: cpu executed OUT, outr is valid.
inp_ack  input  1  one-cycle pulse: cpu executed INP and consumed inpr.
err_clr  input  1  clears sticky rx_ovr and frame_err.
rx  input  1  serial input; asynchronous, idle high.
tx  output  1  serial output; idle high.
inpr  output  8  received byte (cpu keyboard input).
fgi  output  1  input flag: new byte available (to cpu en_inp).
fgo  output  1  output flag: transmitter ready (to cpu en_out).
rx_ovr  output  1  sticky: byte received while fgi already set.
frame_err  output  1  sticky: stop bit sampled low.

Behaviour:
- Reset values: tx=1, inpr=8'h00, fgi=0, fgo=1, rx_ovr=0, frame_err=0. Both FSMs go to IDLE and all counters clear.
- Reset mid-frame aborts the frame. tx is 1 from the next edge, and no partial byte reaches inpr.
- TX FSM states: IDLE, START, DATA, STOP.
  - out_load with fgo=1:
    - outr is latched into a shift register.
    - fgo goes to 0 and tx goes to 0 (start bit), both registered on the next edge.
  - Each bit lasts exactly CLKS_PER_BIT cycles.
  - Data bits are sent LSB first, followed by one stop bit (1).
  - fgo returns to 1 on the edge that ends the stop bit, 10*CLKS_PER_BIT cycles after tx first fell. The FSM returns to IDLE on the same edge.
  - out_load while fgo=0 is ignored; the frame in progress is unaffected.
  - Back-to-back: an out_load in the same cycle fgo rises is ignored. It is accepted from the following cycle.
- RX path: rx passes through a 2-flop synchronizer, adding 2 cycles of latency. All decisions use the synchronized value.
- RX FSM states: IDLE, START, DATA, STOP.
  - IDLE to START on a synchronized falling edge.
  - In START, at CLKS_PER_BIT/2 cycles: if rx is still 0, go to DATA. Otherwise the event is a glitch; return to IDLE and leave all flags unchanged.
  - In DATA, sample once every CLKS_PER_BIT cycles (mid-bit), 8 samples, LSB first.
  - In STOP, take the mid-bit sample:
    - Sample =1: inpr <= byte and fgi <= 1 on that edge. If fgi was already 1 (and not being acked that cycle), rx_ovr <= 1. inpr is overwritten either way.
    - Sample =0: frame_err <= 1; the byte is discarded; inpr and fgi are unchanged.
  - The FSM returns to IDLE right after the stop sample and can detect the next start edge immediately.
- inp_ack clears fgi on the next edge.
  - inp_ack coinciding with a completed byte: fgi stays 1, inpr gets the new byte, no overrun.
- err_clr clears both sticky flags. A new error event in the same cycle wins and the flag stays set.
- TX and RX are fully independent and may run simultaneously.
- Bit counters are width $clog2(CLKS_PER_BIT) and wrap to 0 at CLKS_PER_BIT-1.

Decomposition:
- Shared package up16_io_pkg holds:
  - the 2-bit uart_state_t enum (IDLE, START, DATA, STOP);
  - DATA_BITS=8;
  - FRAME_BITS=10.
- The natural sub-module is io_uart_rx: synchronizer, RX FSM, inpr/fgi/rx_ovr/frame_err logic.
- TX logic stays in io_uart top.

Test Plan:
- Reset then idle → tx=1, fgo=1, fgi=0, inpr=8'h00. Assert rst mid-TX frame → tx=1 on the next edge and fgo=1.
- out_load with outr=8'hA5 → next edge tx=0. Bits sampled at mid-bit are 1,0,1,0,0,1,0,1, then stop=1. fgo low for exactly 160 cycles (CLKS_PER_BIT=16).
- out_load at cycle 50 of a frame in progress with outr=8'h3C → ignored. The frame completes as 8'hA5; the next load after fgo=1 sends 8'h3C.
- Drive rx frame 8'h77 → fgi=1 and inpr=8'h77 at the stop-sample edge. inp_ack → fgi=0 on the next edge.
- Two frames 8'h77 then 8'h88 with no inp_ack → inpr=8'h88, rx_ovr=1. Repeat with inp_ack coincident with the second completion → fgi=1, rx_ovr=0.
- 6-cycle low glitch on rx → no state change. Frame 8'hEE with stop bit 0 → frame_err=1, inpr unchanged. err_clr → frame_err=0.
